// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply / divide sequencer that borrows the core's
// 32-bit ALU for one add or subtract per cycle.
//
// Handshake: start is accepted only when the block is idle (busy=0); the
// operands and op are captured on that edge. busy stays high until the
// operation has finished or been flushed. done is a single-cycle pulse that
// marks res_hi/res_lo/div_by_zero as valid. A start seen while busy is dropped,
// not queued.
module alu_muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo,
  output logic            div_by_zero,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_carry,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(ITER);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  // hi/lo hold the product halves for MUL and the remainder/quotient for DIV.
  logic [XLEN-1:0] hi, lo;
  // Multiplicand for MUL, divisor for DIV.
  logic [XLEN-1:0] mcand;
  logic            dbz_q;

  logic [XLEN-1:0] rem_shift;
  logic            div_ge;
  logic            last_iter;

  // Shifted remainder; a set R[31] means it already exceeds any 32-bit divisor.
  assign rem_shift = {hi[XLEN-2:0], lo[XLEN-1]};
  assign div_ge    = alu_carry | hi[XLEN-1];
  assign last_iter = (cnt == CW'(ITER - 1));

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state selection and ALU operand steering.
  always_comb begin
    state_n  = state;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!op)                state_n = S_MUL;
          else if (src_b == '0)   state_n = S_DONE;
          else                    state_n = S_DIV;
        end
      end
      S_MUL: begin
        alu_a    = hi;
        alu_b    = lo[0] ? mcand : '0;
        alu_ctrl = ALU_ADD;
        if (last_iter) state_n = S_DONE;
      end
      S_DIV: begin
        alu_a    = rem_shift;
        alu_b    = mcand;
        alu_ctrl = ALU_SUB;
        if (last_iter) state_n = S_DONE;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  // Operand capture, per-iteration update and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      mcand       <= '0;
      dbz_q       <= 1'b0;
      done        <= 1'b0;
      res_hi      <= '0;
      res_lo      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              cnt         <= '0;
              div_by_zero <= 1'b0;
              dbz_q       <= op && (src_b == '0);
              if (!op) begin
                hi    <= '0;
                lo    <= src_b;
                mcand <= src_a;
              end else if (src_b == '0) begin
                hi    <= src_a;
                lo    <= '1;
                mcand <= src_b;
              end else begin
                hi    <= '0;
                lo    <= src_a;
                mcand <= src_b;
              end
            end
          end
          S_MUL: begin
            {hi, lo} <= {alu_carry, alu_result, lo[XLEN-1:1]};
            cnt      <= last_iter ? '0 : cnt + 1'b1;
          end
          S_DIV: begin
            hi  <= div_ge ? alu_result : rem_shift;
            lo  <= {lo[XLEN-2:0], div_ge};
            cnt <= last_iter ? '0 : cnt + 1'b1;
          end
          S_DONE: begin
            done        <= 1'b1;
            res_hi      <= hi;
            res_lo      <= lo;
            div_by_zero <= dbz_q;
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that computes unsigned 32x32 multiply (64-bit product) and unsigned 32/32 divide (quotient, remainder) by time-sharing the core's existing 32-bit ALU.
- Drives ALU operands and ALU control for one add or subtract per cycle.
- Consumes the ALU Result and carry flag.
- Sits beside the single-cycle datapath; the core stalls on busy and muxes the ALU inputs to this block while busy=1.

Parameters:
XLEN, 32, operand width; must equal ALU width (only 32 supported).
ITER, 32, iterations per operation; must equal XLEN.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  1  0=MULU, 1=DIVU; sampled with start
src_a  input  32  multiplicand / dividend; sampled with start
src_b  input  32  multiplier / divisor; sampled with start
flush  input  1  synchronous abort; return to IDLE, no done
busy  output  1  high in MUL, DIV, DONE states
done  output  1  one-cycle pulse; results valid
res_hi  output  32  MULU: product[63:32]; DIVU: remainder
res_lo  output  32  MULU: product[31:0]; DIVU: quotient
div_by_zero  output  1  valid with done; set when DIVU and src_b==0
alu_a  output  32  ALU operand A
alu_b  output  32  ALU operand B
alu_ctrl  output  3  ALU control: 3'b000 add, 3'b001 subtract
alu_result  input  32  ALU Result, combinational from alu_a/alu_b/alu_ctrl
alu_carry  input  1  ALU C flag (add: carry-out; subtract: 1 = no borrow, A>=B)

Behaviour:
- Reset (async):
  - State=IDLE.
  - busy, done, div_by_zero = 0.
  - res_hi, res_lo = 0.
  - alu_a, alu_b, alu_ctrl = 0.
  - Iteration counter = 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1:
  - Latch src_a and src_b into the internal registers.
  - op=0 -> MUL: hi=0, lo=src_b, mcand=src_a.
  - op=1, src_b!=0 -> DIV: R=0, Q=src_a, D=src_b.
  - op=1, src_b==0 -> DONE directly: res_lo=32'hFFFFFFFF, res_hi=src_a, div_by_zero=1.
- start outside IDLE is ignored (no queueing).
- MUL iteration (one per cycle, 32 cycles):
  - alu_a=hi, alu_b = lo[0] ? mcand : 0, alu_ctrl=000.
  - Update {hi,lo} <= {alu_carry, alu_result, lo[31:1]}.
- DIV iteration (one per cycle, 32 cycles, restoring):
  - Rs = {R[30:0], Q[31]}.
  - alu_a=Rs, alu_b=D, alu_ctrl=001.
  - ge = alu_carry | R[31]. R[31]=1 means the shifted remainder is >= 2^32 > D, so the wrapped difference is correct.
  - ge=1: R <= alu_result, Q <= {Q[30:0],1}.
  - ge=0: R <= Rs, Q <= {Q[30:0],0}.
- Counter counts 0..31. After the update with counter==31, go to DONE.
- In IDLE and DONE: alu_a=0, alu_b=0, alu_ctrl=000. These outputs are combinational from state and registers.
- DONE lasts one cycle:
  - done=1.
  - res_hi/res_lo = hi/lo (MUL) or R/Q (DIV).
  - Next state IDLE.
- res_hi, res_lo, div_by_zero hold until the next accepted start. div_by_zero clears on the next start.
- Latency, start sampled at edge k:
  - Normal: iterations on edges k+1..k+32; done high in the cycle after edge k+33.
  - Divide by zero: done high in the cycle after edge k+1.
- busy is high the cycle after start is accepted, through the DONE cycle.
- flush=1 in any state:
  - Next state IDLE, counter=0.
  - No done pulse; result outputs keep their old values.
  - flush has priority over start in the same cycle.
- Reset mid-operation: immediate return to reset values; no done pulse.

Test Plan:
- MULU src_a=7, src_b=6 -> done exactly 33 cycles after start; res_hi=0, res_lo=42; alu_ctrl=000 throughout.
- MULU 32'hFFFFFFFF x 32'hFFFFFFFF -> res_hi=32'hFFFFFFFE, res_lo=32'h00000001 (checks carry into hi).
- DIVU 100/7 -> res_lo=14, res_hi=2. DIVU 32'hFFFFFFFF/32'hFFFFFFFE -> res_lo=1, res_hi=1 (R[31] path). Both with div_by_zero=0.
- DIVU 1234/0 -> done 1 cycle after start; res_lo=32'hFFFFFFFF, res_hi=1234, div_by_zero=1.
- Start MULU 3x5, then pulse start with op=1 at cycle 10 -> second request ignored; result 15. flush at cycle 20 of another op -> busy=0 next cycle, no done, res_lo stays 15.
- Assert rst at iteration 16 of a DIVU -> all outputs 0 immediately. A new MULU 2x2 after release -> res_lo=4.
